// File: rtl/core_seq.sv
// Tile sequencer for the corelet: weight L0 fill, kernel load, activation L0 fill, execute, output drain.
// Optional relu flag on accumulated output is enabled by defining CORE_SEQ_RELU_EN.
module core_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         num_x,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, W_L0, W_LOAD, X_L0, EXEC, DRAIN, FIN
  } state_e;

  localparam int CW = 16;
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] W_END  = CW'(col - 1);
  localparam logic [CW-1:0] L_END  = CW'(row + col - 1);
  localparam logic [CW-1:0] RC_LEN = CW'(row + col);
  localparam logic [addr_bw-1:0] ADDR_ONE = addr_bw'(1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           numx_q, numx_d;
  logic [7:0]           rd_q, rd_d;
  logic [addr_bw-1:0]   addr_q, addr_d;
  logic [CW-1:0]        numx_ext;

  logic cen_q, cen_d;
  logic kload_q, kload_d;
  logic exec_q, exec_d;
  logic l0rd_q, l0rd_d;
  logic ofrd_q, ofrd_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic l0wr_q;
  logic acc_q;
  logic relu_bit;

  assign numx_ext = {{(CW-8){1'b0}}, numx_q};

  // ofifo_valid acts as a valid with inst[6] as the pop: a pop is issued on the
  // edge where ofifo_valid is seen high in DRAIN with reads still owed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    numx_d  = numx_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    ofrd_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = W_L0;
          numx_d  = num_x;
          addr_d  = '0;
        end
      end
      W_L0: begin
        if (cnt_q == W_END) begin
          state_d = W_LOAD;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      W_LOAD: begin
        if (cnt_q == L_END) begin
          cnt_d = '0;
          if (numx_q == 8'd0) begin
            state_d = FIN;
          end else begin
            state_d = X_L0;
            addr_d  = addr_q + ADDR_ONE;
          end
        end
      end
      X_L0: begin
        if (cnt_q == numx_ext - ONE) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      EXEC: begin
        if (cnt_q == numx_ext + RC_LEN - ONE) begin
          state_d = DRAIN;
          cnt_d   = '0;
          rd_d    = numx_q;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q;
        if (rd_q == 8'd0) begin
          state_d = FIN;
        end else if (ofifo_valid) begin
          ofrd_d = 1'b1;
          rd_d   = rd_q - 8'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the upcoming state so the registered copies line up with state_q.
    cen_d   = !(state_d == W_L0 || state_d == X_L0);
    kload_d = (state_d == W_LOAD);
    exec_d  = (state_d == EXEC);
    l0rd_d  = kload_d || (exec_d && (cnt_d < numx_ext));
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      numx_q  <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      cen_q   <= 1'b1;
      kload_q <= 1'b0;
      exec_q  <= 1'b0;
      l0rd_q  <= 1'b0;
      ofrd_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      l0wr_q  <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      numx_q  <= numx_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      cen_q   <= cen_d;
      kload_q <= kload_d;
      exec_q  <= exec_d;
      l0rd_q  <= l0rd_d;
      ofrd_q  <= ofrd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      // L0 write trails the SRAM enable by one cycle to absorb read latency.
      l0wr_q  <= ~cen_q;
      acc_q   <= ofrd_q;
    end
  end

`ifdef CORE_SEQ_RELU_EN
  logic relu_q;
  always_ff @(posedge clk) begin
    if (reset) relu_q <= 1'b0;
    else       relu_q <= ofrd_q;
  end
  assign relu_bit = relu_q;
`else
  assign relu_bit = 1'b0;
`endif

  assign inst      = {acc_q, 26'd0, ofrd_q, relu_bit, 1'b0, l0rd_q, l0wr_q, exec_q, kload_q};
  assign xmem_cen  = cen_q;
  assign xmem_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: table of tile runs with a per-cycle expected trace built from the phase timeline.
// Honours CORE_SEQ_RELU_EN when the same macro is defined for the build.
module tb_core_seq;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int AW   = 4;
  localparam int W    = 3 + AW + 34;
  localparam int MAXC = 1024;
  localparam int NVEC = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    num_x;
  logic          ofifo_valid;
  logic [33:0]   inst;
  logic          xmem_cen;
  logic [AW-1:0] xmem_addr;
  logic          busy;
  logic          done;

  core_seq #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_x(num_x),
    .ofifo_valid(ofifo_valid), .inst(inst), .xmem_cen(xmem_cen),
    .xmem_addr(xmem_addr), .busy(busy), .done(done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int          nx;
    logic [15:0] vpat;     // ofifo_valid per DRAIN cycle, bit 0 first; 1 beyond vlen
    int          vlen;
    bit          poke;     // pulse start while busy and in FIN
    int          rst_at;   // cycle to assert reset (0 = never)
    int          exp_fin;  // expected done cycle counted from start acceptance
  } vec_t;

  vec_t          vecs[NVEC];
  logic [W-1:0]  exp_q[$];
  bit            vin[MAXC];
  logic [AW-1:0] last_addr;
  int            n_cmp;
  int            n_bad;

  function automatic logic [W-1:0] pack(bit b, bit d, bit c, logic [AW-1:0] a, logic [33:0] i);
    return {b, d, c, a, i};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {busy, done, xmem_cen, xmem_addr, inst};
  endfunction

  task automatic check(input string name, input int cyc, input logic [W-1:0] got, input logic [W-1:0] exp_w);
    n_cmp++;
    if (got !== exp_w) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp_w);
    end
  endtask

  // Expected trace from the phase timeline; pushes cycles 1..fin+2 to exp_q.
  task automatic build(input vec_t v, output int fin);
    bit            cen_a[MAXC];
    bit            i0[MAXC], i1[MAXC], i3[MAXC], i6[MAXC];
    logic [AW-1:0] ad[MAXC];
    logic [AW-1:0] a;
    logic [33:0]   iw;
    int p1, p2, p3, p4, t, rem, d;
    for (int k = 0; k < MAXC; k++) begin
      cen_a[k] = 1'b1; i0[k] = 1'b0; i1[k] = 1'b0; i3[k] = 1'b0; i6[k] = 1'b0;
      ad[k] = '0;
      vin[k] = 1'($urandom_range(0, 1));
    end
    p1 = COL;
    p2 = p1 + ROW + COL;
    p3 = p2 + v.nx;
    p4 = (v.nx > 0) ? p3 + v.nx + ROW + COL : p3;
    for (int k = 1; k <= p1; k++) begin cen_a[k] = 1'b0; ad[k] = AW'(k - 1); end
    for (int k = p1 + 1; k <= p2; k++) begin i0[k] = 1'b1; i3[k] = 1'b1; end
    for (int k = p2 + 1; k <= p3; k++) begin cen_a[k] = 1'b0; ad[k] = AW'(COL + k - p2 - 1); end
    for (int k = p3 + 1; k <= p4; k++) begin i1[k] = 1'b1; i3[k] = ((k - p3) <= v.nx); end
    if (v.nx > 0) begin
      for (int k = p4 + 1; k < MAXC; k++) begin
        d = k - (p4 + 1);
        vin[k] = (d < v.vlen) ? v.vpat[d] : 1'b1;
      end
      rem = v.nx;
      t = p4 + 1;
      while (rem > 0 && t < MAXC - 4) begin
        if (vin[t]) begin i6[t+1] = 1'b1; rem--; end
        t++;
      end
      fin = t + 1;
    end else begin
      fin = p2 + 1;
    end
    a = last_addr;
    for (int k = 1; k <= fin + 2; k++) begin
      if (!cen_a[k]) a = ad[k];
      iw = '0;
      iw[0]  = i0[k];
      iw[1]  = i1[k];
      iw[2]  = !cen_a[k-1];
      iw[3]  = i3[k];
      iw[6]  = i6[k];
      iw[33] = i6[k-1];
`ifdef CORE_SEQ_RELU_EN
      iw[5]  = i6[k-1];
`endif
      exp_q.push_back(pack(k <= fin, k == fin, cen_a[k], a, iw));
    end
    last_addr = a;
  endtask

  // Driver: entered and left at the falling edge of an idle cycle.
  task automatic run_tile(input int idx);
    vec_t v;
    int fin, t_done, n_done;
    logic [W-1:0] exp_w;
    string nm;
    v = vecs[idx];
    nm = $sformatf("vec%0d_trace", idx);
    build(v, fin);
    num_x = 8'(v.nx);
    start = 1'b1;
    ofifo_valid = vin[0];
    t_done = 0;
    n_done = 0;
    for (int t = 1; t <= fin + 2; t++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      check(nm, t, dut_word(), exp_w);
      if (done) begin
        n_done++;
        if (t_done == 0) t_done = t;
      end
      start = v.poke && (t == 5 || t == 30 || t == fin);
      num_x = 8'($urandom_range(0, 255));
      ofifo_valid = vin[t];
      if (v.rst_at != 0 && t == v.rst_at) begin
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_reset_next", idx), t + 1, dut_word(), pack(0, 0, 1, AW'(0), 34'd0));
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d_reset_idle", idx), t + 2, dut_word(), pack(0, 0, 1, AW'(0), 34'd0));
        exp_q.delete();
        last_addr = '0;
        return;
      end
    end
    n_cmp++;
    if (t_done != v.exp_fin || n_done != 1) begin
      n_bad++;
      $display("FAIL vec%0d_done_cycle got cyc=%0d pulses=%0d exp cyc=%0d pulses=1",
               idx, t_done, n_done, v.exp_fin);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_addr = '0;
    vecs[0]  = '{nx: 4,   vpat: 16'b101101, vlen: 6, poke: 0, rst_at: 0,  exp_fin: 56};
    vecs[1]  = '{nx: 0,   vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 0,  exp_fin: 25};
    vecs[2]  = '{nx: 1,   vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 0,  exp_fin: 45};
    vecs[3]  = '{nx: 3,   vpat: 16'b111000, vlen: 6, poke: 0, rst_at: 0,  exp_fin: 54};
    vecs[4]  = '{nx: 4,   vpat: 16'b0,      vlen: 0, poke: 1, rst_at: 0,  exp_fin: 54};
    vecs[5]  = '{nx: 10,  vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 0,  exp_fin: 72};
    vecs[6]  = '{nx: 255, vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 0,  exp_fin: 807};
    vecs[7]  = '{nx: 4,   vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 31, exp_fin: 0};
    vecs[8]  = '{nx: 4,   vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 0,  exp_fin: 54};
    vecs[9]  = '{nx: 4,   vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 3,  exp_fin: 0};
    vecs[10] = '{nx: 4,   vpat: 16'b0,      vlen: 0, poke: 0, rst_at: 50, exp_fin: 0};
    vecs[11] = '{nx: 2,   vpat: 16'b1010,   vlen: 4, poke: 0, rst_at: 0,  exp_fin: 50};

    // reset, with start held high to show reset wins
    reset = 1'b1;
    start = 1'b1;
    num_x = 8'd4;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 0, dut_word(), pack(0, 0, 1, AW'(0), 34'd0));
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 0, dut_word(), pack(0, 0, 1, AW'(0), 34'd0));

    for (int i = 0; i < NVEC; i++) run_tile(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
